// File: rtl/sd_resp_parser_if.sv
// Link between the command FSM (master) and the CMD-line response parser (slave),
// carrying the control handshake, result flags and the register-bank load ports.
interface sd_resp_parser_if;
    logic         bit_en;
    logic         cmd_in;
    logic         start;
    logic [2:0]   resp_type;
    logic [5:0]   exp_index;
    logic         r2_is_cid;
    logic         busy;
    logic         done;
    logic         timeout;
    logic         frame_err;
    logic         idx_err;
    logic         crc_err;
    logic [127:0] cid_data;
    logic         cid_en;
    logic [127:0] csd_data;
    logic         csd_en;
    logic [31:0]  ocr_data;
    logic         ocr_en;
    logic [15:0]  rca_data;
    logic         rca_en;
    logic [63:0]  stat_data;
    logic         stat_en;

    modport master (
        output bit_en, cmd_in, start, resp_type, exp_index, r2_is_cid,
        input  busy, done, timeout, frame_err, idx_err, crc_err,
               cid_data, cid_en, csd_data, csd_en, ocr_data, ocr_en,
               rca_data, rca_en, stat_data, stat_en
    );

    modport slave (
        input  bit_en, cmd_in, start, resp_type, exp_index, r2_is_cid,
        output busy, done, timeout, frame_err, idx_err, crc_err,
               cid_data, cid_en, csd_data, csd_en, ocr_data, ocr_en,
               rca_data, rca_en, stat_data, stat_en
    );
endinterface

// File: rtl/sd_resp_parser.sv
// SD CMD-line response parser: frames R1/R1b/R2/R3/R6/R7, checks fields and loads the card registers.
// Optional serial CRC7 checking is enabled with the SD_RESP_CRC_EN macro.
module sd_resp_parser #(
    parameter int NCR_MAX = 64
) (
    input  logic            clk,
    input  logic            reset,
    sd_resp_parser_if.slave bus
);
    localparam int NCR_W = $clog2(NCR_MAX);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_CHECK = 2'd3;

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_R1   = 3'd1;
    localparam logic [2:0] T_R2   = 3'd2;
    localparam logic [2:0] T_R3   = 3'd3;
    localparam logic [2:0] T_R6   = 3'd6;
    localparam logic [2:0] T_R7   = 3'd7;

    logic [1:0]       state;
    logic [2:0]       rtype;
    logic [5:0]       exp_idx;
    logic             to_cid;
    logic [NCR_W-1:0] ncr_cnt;
    logic [7:0]       bit_cnt;
    logic [135:0]     sr;

    logic             is_r2;
    logic [7:0]       last_idx;
    logic [31:0]      payload;
    logic [31:0]      r6_status;
    logic             frame_bad;
    logic             idx_bad;
    logic             crc_bad;

    function automatic logic type_known(input logic [2:0] t);
        return t inside {T_R1, T_R2, T_R3, T_R6, T_R7};
    endfunction

    assign bus.busy = (state != S_IDLE);
    assign is_r2    = (rtype == T_R2);
    assign last_idx = is_r2 ? 8'd135 : 8'd47;
    assign payload  = sr[39:8];

    // Start and tx bits must be 0, end bit 1; R2 carries a fixed 6'h3F in the index field.
    assign frame_bad = is_r2 ? (sr[135] | sr[134] | ~sr[0]) : (sr[47] | sr[46] | ~sr[0]);
    assign idx_bad   = is_r2 ? (sr[133:128] != 6'h3F)
                             : ((rtype != T_R3) && (sr[45:40] != exp_idx));

    always_comb begin
        r6_status       = '0;
        r6_status[23]   = payload[15];
        r6_status[22]   = payload[14];
        r6_status[19]   = payload[13];
        r6_status[12:0] = payload[12:0];
    end

`ifdef SD_RESP_CRC_EN
    logic [6:0] crc;
    logic       crc_on;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // 48-bit frames cover bits [47:8]; R2 covers only the register bits [127:8].
    assign crc_on = is_r2 ? ((bit_cnt >= 8'd8) && (bit_cnt <= 8'd127)) : (bit_cnt <= 8'd39);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            crc <= '0;
        else if (state == S_WAIT)
            crc <= '0;
        else if ((state == S_SHIFT) && bus.bit_en && crc_on)
            crc <= crc7_step(crc, bus.cmd_in);
    end

    assign crc_bad = (rtype != T_R3) && (crc != sr[7:1]);
`else
    assign crc_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            rtype         <= T_NONE;
            exp_idx       <= '0;
            to_cid        <= 1'b0;
            ncr_cnt       <= '0;
            bit_cnt       <= '0;
            sr            <= '0;
            bus.done      <= 1'b0;
            bus.timeout   <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.idx_err   <= 1'b0;
            bus.crc_err   <= 1'b0;
            bus.cid_data  <= '0;
            bus.cid_en    <= 1'b0;
            bus.csd_data  <= '0;
            bus.csd_en    <= 1'b0;
            bus.ocr_data  <= '0;
            bus.ocr_en    <= 1'b0;
            bus.rca_data  <= '0;
            bus.rca_en    <= 1'b0;
            bus.stat_data <= '0;
            bus.stat_en   <= 1'b0;
        end else begin
            bus.done    <= 1'b0;
            bus.cid_en  <= 1'b0;
            bus.csd_en  <= 1'b0;
            bus.ocr_en  <= 1'b0;
            bus.rca_en  <= 1'b0;
            bus.stat_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        bus.timeout   <= 1'b0;
                        bus.frame_err <= 1'b0;
                        bus.idx_err   <= 1'b0;
                        bus.crc_err   <= 1'b0;
                        exp_idx       <= bus.exp_index;
                        to_cid        <= bus.r2_is_cid;
                        ncr_cnt       <= '0;
                        if (type_known(bus.resp_type)) begin
                            rtype <= bus.resp_type;
                            state <= S_WAIT;
                        end else begin
                            rtype         <= T_NONE;
                            bus.done      <= 1'b1;
                            bus.stat_en   <= 1'b1;
                            bus.stat_data <= {26'b0, 6'h3F, 32'b0};
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.bit_en) begin
                        if (!bus.cmd_in) begin
                            state   <= S_SHIFT;
                            sr      <= '0;
                            bit_cnt <= 8'd1;
                        end else if (ncr_cnt == NCR_W'(NCR_MAX - 1)) begin
                            state       <= S_IDLE;
                            bus.done    <= 1'b1;
                            bus.timeout <= 1'b1;
                        end else begin
                            ncr_cnt <= ncr_cnt + 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (bus.bit_en) begin
                        sr      <= {sr[134:0], bus.cmd_in};
                        bit_cnt <= bit_cnt + 8'd1;
                        if (bit_cnt == last_idx)
                            state <= S_CHECK;
                    end
                end
                default: begin
                    // S_CHECK: frame fully aligned at sr[0]; publish flags and loads together.
                    state         <= S_IDLE;
                    bus.done      <= 1'b1;
                    bus.frame_err <= frame_bad;
                    bus.idx_err   <= idx_bad;
                    bus.crc_err   <= crc_bad;
                    if (!(frame_bad || idx_bad || crc_bad)) begin
                        case (rtype)
                            T_R1, T_R7: begin
                                bus.stat_en   <= 1'b1;
                                bus.stat_data <= {26'b0, sr[45:40], payload};
                            end
                            T_R2: begin
                                if (to_cid) begin
                                    bus.cid_en   <= 1'b1;
                                    bus.cid_data <= {sr[127:1], 1'b1};
                                end else begin
                                    bus.csd_en   <= 1'b1;
                                    bus.csd_data <= {sr[127:1], 1'b1};
                                end
                            end
                            T_R3: begin
                                bus.ocr_en   <= 1'b1;
                                bus.ocr_data <= payload;
                            end
                            T_R6: begin
                                bus.rca_en    <= 1'b1;
                                bus.rca_data  <= payload[31:16];
                                bus.stat_en   <= 1'b1;
                                bus.stat_data <= {26'b0, sr[45:40], r6_status};
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sd_resp_parser.sv
// Directed bench for sd_resp_parser: builds CMD-line frames with a reference CRC7
// and checks flags, load pulses and register data.
`timescale 1ns/1ps
module tb_sd_resp_parser;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   strobe_cyc = 0;
    int   start_cyc = 0;

    sd_resp_parser_if bus ();

    sd_resp_parser #(.NCR_MAX(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int done_cnt = 0, cid_cnt = 0, csd_cnt = 0, ocr_cnt = 0, rca_cnt = 0, stat_cnt = 0;
    int done_cyc = 0;

    always @(negedge clk) begin
        if (bus.done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (bus.cid_en)  cid_cnt  = cid_cnt + 1;
        if (bus.csd_en)  csd_cnt  = csd_cnt + 1;
        if (bus.ocr_en)  ocr_cnt  = ocr_cnt + 1;
        if (bus.rca_en)  rca_cnt  = rca_cnt + 1;
        if (bus.stat_en) stat_cnt = stat_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Polynomial long division by x^7+x^3+1 of msg * x^7.
    function automatic logic [6:0] crc7_ref(input logic [119:0] msg, input int nbits);
        logic [127:0] rem;
        rem = 128'(msg) << 7;
        for (int i = nbits + 6; i >= 7; i--)
            if (rem[i]) rem[i -: 8] = rem[i -: 8] ^ 8'h89;
        return rem[6:0];
    endfunction

    function automatic logic [135:0] mk48(input logic [5:0] idx, input logic [31:0] p);
        logic [39:0] m;
        m = {2'b00, idx, p};
        return {88'b0, m, crc7_ref(120'(m), 40), 1'b1};
    endfunction

    function automatic logic [135:0] mk136(input logic [119:0] c);
        return {2'b00, 6'h3F, c, crc7_ref(c, 120), 1'b1};
    endfunction

    task automatic strobe(input logic b);
        bus.cmd_in = b;
        bus.bit_en = 1'b1;
        strobe_cyc = cyc;
        @(negedge clk);
        bus.bit_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic send(input logic [135:0] f, input int n);
        for (int i = n - 1; i >= 0; i--) strobe(f[i]);
    endtask

    task automatic pulse_start(input logic [2:0] t, input logic [5:0] idx, input logic cid);
        bus.resp_type = t;
        bus.exp_index = idx;
        bus.r2_is_cid = cid;
        bus.start     = 1'b1;
        start_cyc     = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        #1;
    endtask

    initial begin
        logic [135:0] f;
        logic [119:0] content;
        int d0, c0, s0, o0, r0, k0, e0;

        reset = 1'b0;
        bus.bit_en = 1'b0; bus.cmd_in = 1'b1; bus.start = 1'b0;
        bus.resp_type = 3'd0; bus.exp_index = 6'd0; bus.r2_is_cid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_flags", {bus.timeout, bus.frame_err, bus.idx_err, bus.crc_err}, 0);
        chk("rst_en", {bus.cid_en, bus.csd_en, bus.ocr_en, bus.rca_en, bus.stat_en}, 0);
        chk("rst_stat", bus.stat_data, 0);
        chk("rst_cid", bus.cid_data, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // R1 CMD17 echo
        d0 = done_cnt; s0 = stat_cnt;
        pulse_start(3'd1, 6'd17, 1'b0);
        #1 chk("r1_busy", bus.busy, 1);
        strobe(1'b1); strobe(1'b1);
        send(mk48(6'd17, 32'h0000_0900), 48);
        settle();
        chk("r1_done", done_cnt - d0, 1);
        chk("r1_latency", done_cyc - strobe_cyc, 2);
        chk("r1_stat_en", stat_cnt - s0, 1);
        chk("r1_stat", bus.stat_data, 128'h0000_0011_0000_0900);
        chk("r1_flags", {bus.timeout, bus.frame_err, bus.idx_err, bus.crc_err}, 0);
        chk("r1_idle", bus.busy, 0);

        // R2 into CID
        content = {24'h035344, 32'h5344_3136, 32'h4780_4567, 32'h89AB_CD01};
        d0 = done_cnt; c0 = cid_cnt; k0 = csd_cnt;
        pulse_start(3'd2, 6'd2, 1'b1);
        strobe(1'b1);
        send(mk136(content), 136);
        settle();
        chk("r2_done", done_cnt - d0, 1);
        chk("r2_cid_en", cid_cnt - c0, 1);
        chk("r2_csd_en", csd_cnt - k0, 0);
        chk("r2_cid", bus.cid_data, {content, crc7_ref(content, 120), 1'b1});
        chk("r2_cid_lsb", bus.cid_data[0], 1);
        chk("r2_flags", {bus.timeout, bus.frame_err, bus.idx_err, bus.crc_err}, 0);

        // R1 with payload bit 12 flipped
        f = mk48(6'd17, 32'h0000_0900);
        f[20] = ~f[20];
        d0 = done_cnt; s0 = stat_cnt;
        pulse_start(3'd1, 6'd17, 1'b0);
        send(f, 48);
        settle();
        chk("flip_done", done_cnt - d0, 1);
`ifdef SD_RESP_CRC_EN
        chk("flip_crc_err", bus.crc_err, 1);
        chk("flip_stat_en", stat_cnt - s0, 0);
        chk("flip_stat_hold", bus.stat_data, 128'h0000_0011_0000_0900);
`else
        chk("flip_crc_err", bus.crc_err, 0);
        chk("flip_stat_en", stat_cnt - s0, 1);
        chk("flip_stat", bus.stat_data, 128'h0000_0011_0000_1900);
`endif

        // No start bit within NCR_MAX strobes
        d0 = done_cnt;
        e0 = cid_cnt + csd_cnt + ocr_cnt + rca_cnt + stat_cnt;
        pulse_start(3'd1, 6'd5, 1'b0);
        repeat (63) strobe(1'b1);
        #1;
        chk("to_not_yet", done_cnt - d0, 0);
        chk("to_busy", bus.busy, 1);
        strobe(1'b1);
        #1;
        chk("to_done", done_cnt - d0, 1);
        chk("to_latency", done_cyc - strobe_cyc, 1);
        chk("to_flag", {bus.timeout, bus.frame_err, bus.idx_err, bus.crc_err}, 4'b1000);
        chk("to_no_en", (cid_cnt + csd_cnt + ocr_cnt + rca_cnt + stat_cnt) - e0, 0);
        chk("to_idle", bus.busy, 0);

        // R6, with a stray start while armed
        d0 = done_cnt; r0 = rca_cnt; s0 = stat_cnt;
        pulse_start(3'd6, 6'd3, 1'b0);
        #1 chk("start_clears_to", bus.timeout, 0);
        strobe(1'b1);
        pulse_start(3'd0, 6'd0, 1'b0);
        send(mk48(6'd3, 32'hAAAA_E500), 48);
        settle();
        chk("r6_done", done_cnt - d0, 1);
        chk("r6_rca_en", rca_cnt - r0, 1);
        chk("r6_stat_en", stat_cnt - s0, 1);
        chk("r6_rca", bus.rca_data, 16'hAAAA);
        chk("r6_stat", bus.stat_data[31:0], 32'h00C8_0500);

        // R3: index/CRC fields fixed, not checked
        o0 = ocr_cnt;
        pulse_start(3'd3, 6'd5, 1'b0);
        send({88'b0, 2'b00, 6'h3F, 32'h80FF_8000, 7'h7F, 1'b1}, 48);
        settle();
        chk("r3_ocr_en", ocr_cnt - o0, 1);
        chk("r3_ocr", bus.ocr_data, 32'h80FF_8000);
        chk("r3_flags", {bus.timeout, bus.frame_err, bus.idx_err, bus.crc_err}, 0);

        // R7 with wrong echoed index
        d0 = done_cnt; s0 = stat_cnt;
        pulse_start(3'd7, 6'd8, 1'b0);
        send(mk48(6'd9, 32'h0000_01AA), 48);
        settle();
        chk("idx_done", done_cnt - d0, 1);
        chk("idx_flag", {bus.timeout, bus.frame_err, bus.idx_err, bus.crc_err}, 4'b0010);
        chk("idx_no_en", stat_cnt - s0, 0);

        // R1 with bad end bit
        f = mk48(6'd9, 32'h0000_0000);
        f[0] = 1'b0;
        s0 = stat_cnt;
        pulse_start(3'd1, 6'd9, 1'b0);
        #1 chk("start_clears_idx", bus.idx_err, 0);
        send(f, 48);
        settle();
        chk("frm_flag", bus.frame_err, 1);
        chk("frm_no_en", stat_cnt - s0, 0);

        // No response expected
        d0 = done_cnt; s0 = stat_cnt;
        pulse_start(3'd0, 6'd0, 1'b0);
        settle();
        chk("none_done", done_cnt - d0, 1);
        chk("none_latency", done_cyc - start_cyc, 1);
        chk("none_stat_en", stat_cnt - s0, 1);
        chk("none_stat", bus.stat_data, 128'h0000_003F_0000_0000);
        chk("none_flags", {bus.timeout, bus.frame_err, bus.idx_err, bus.crc_err}, 0);

        // Reset during an R2 shift, then a clean R1
        c0 = cid_cnt; d0 = done_cnt; s0 = stat_cnt;
        f = mk136(content);
        pulse_start(3'd2, 6'd2, 1'b1);
        strobe(1'b1);
        for (int i = 135; i >= 76; i--) strobe(f[i]);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_cid", bus.cid_data, 0);
        chk("mid_rst_stat", bus.stat_data, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        pulse_start(3'd1, 6'd17, 1'b0);
        send(mk48(6'd17, 32'h0000_0900), 48);
        settle();
        chk("post_rst_done", done_cnt - d0, 1);
        chk("post_rst_cid_en", cid_cnt - c0, 0);
        chk("post_rst_stat_en", stat_cnt - s0, 1);
        chk("post_rst_stat", bus.stat_data, 128'h0000_0011_0000_0900);
        chk("post_rst_flags", {bus.timeout, bus.frame_err, bus.idx_err, bus.crc_err}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
